// File: rtl/alu2_pkg.sv
// Shared definitions for the two-client round-robin ALU scheduler:
// ALU op codes and scheduler FSM state encodings.
package alu2_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu2_rr_sched_if.sv
// Client-side bus of the round-robin ALU scheduler: two request/operand
// channels in, grants, done pulses, shared result and status out.
interface alu2_rr_sched_if #(
  parameter int CNT_W = 8
);
  logic             req0;
  logic [3:0]       a0;
  logic [3:0]       b0;
  logic [1:0]       c0;
  logic             req1;
  logic [3:0]       a1;
  logic [3:0]       b1;
  logic [1:0]       c1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [3:0]       result;
  logic             busy;
  logic [CNT_W-1:0] op_cnt;

  // Clients drive requests and operands, observe grants and results.
  modport master (
    output req0, a0, b0, c0, req1, a1, b1, c1,
    input  gnt0, gnt1, done0, done1, result, busy, op_cnt
  );

  // The scheduler consumes requests and returns grants and results.
  modport slave (
    input  req0, a0, b0, c0, req1, a1, b1, c1,
    output gnt0, gnt1, done0, done1, result, busy, op_cnt
  );
endinterface

// File: rtl/alu2.sv
// Combinational 4-bit ALU: add, add with carry-in, AND, XOR.
// Carries out of bit 3 are discarded.
module alu2
  import alu2_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] c,
  output logic [3:0] y
);

  // Select the operation by op code.
  always_comb begin
    y = 4'd0;
    case (c)
      OP_ADD:  y = a + b;
      OP_ADDI: y = a + b + 4'd1;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = 4'd0;
    endcase
  end

endmodule

// File: rtl/alu2_rr_sched.sv
// Round-robin scheduler letting two clients share one alu2 instance.
// Each operation takes IDLE -> EXEC -> DONE; the last owner gets the
// lowest priority when both clients request at once.
module alu2_rr_sched
  import alu2_pkg::*;
#(
  parameter int CNT_W = 8
)(
  input  logic            clk,
  input  logic            rst,
  alu2_rr_sched_if.slave  bus
);

  state_t           state;
  logic             ptr;
  logic             owner;
  logic [3:0]       opa;
  logic [3:0]       opb;
  logic [1:0]       opc;
  logic [3:0]       result_q;
  logic [CNT_W-1:0] op_cnt_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             done0_q;
  logic             done1_q;
  logic             busy_q;
  logic             pick;
  logic [3:0]       alu_y;

  // Counter increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Single shared datapath, always fed from the latched operands.
  alu2 u_alu (
    .a (opa),
    .b (opb),
    .c (opc),
    .y (alu_y)
  );

  // Arbitration: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) pick = ptr;
    else if (bus.req1)        pick = 1'b1;
  end

  // Scheduler FSM with operand, result, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      opa      <= 4'd0;
      opb      <= 4'd0;
      opc      <= 2'd0;
      result_q <= 4'd0;
      op_cnt_q <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req0 || bus.req1) begin
            opa    <= pick ? bus.a1 : bus.a0;
            opb    <= pick ? bus.b1 : bus.b0;
            opc    <= pick ? bus.c1 : bus.c0;
            owner  <= pick;
            gnt0_q <= ~pick;
            gnt1_q <= pick;
            busy_q <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q <= alu_y;
          done0_q  <= ~owner;
          done1_q  <= owner;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          ptr      <= ~owner;
          op_cnt_q <= sat_inc(op_cnt_q);
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          busy_q   <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          gnt0_q <= 1'b0;
          gnt1_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.op_cnt = op_cnt_q;

endmodule

// File: doc/alu2_rr_sched.md
Name: alu2_rr_sched

Overview:
Two-requester round-robin scheduler sharing one 4-bit ALU datapath (alu2: c=00 A+B, 01 A+B+1, 10 A&B, 11 A^B).
- Accepts an operation request (A, B, op code) from either client and latches the operands.
- Drives the single ALU instance, registers the 4-bit result and returns it with a one-cycle done pulse to the owner.
- Sits between the two operand-producing clients and the shared alu2 datapath; also keeps a saturating completed-operation count.

Parameters:
CNT_W, 8, width of the saturating completed-operation counter op_cnt.

Ports:
clk  in  1  system clock, single clock domain, all state on rising edge
rst  in  1  asynchronous, active-high reset
req0  in  1  client 0 request (level); held high until done0 is seen
a0  in  4  client 0 operand A, stable while req0 high
b0  in  4  client 0 operand B, stable while req0 high
c0  in  2  client 0 op code, stable while req0 high
req1  in  1  client 1 request (level)
a1  in  4  client 1 operand A
b1  in  4  client 1 operand B
c1  in  2  client 1 op code
gnt0  out  1  client 0 owns the ALU (high in EXEC and DONE while owner=0)
gnt1  out  1  client 1 owns the ALU (high in EXEC and DONE while owner=1)
done0  out  1  one-cycle pulse: result valid for client 0
done1  out  1  one-cycle pulse: result valid for client 1
result  out  4  registered ALU result, valid while either done is high, holds value otherwise
busy  out  1  high in EXEC and DONE
op_cnt  out  CNT_W  completed operations, saturates at 2^CNT_W-1

Behaviour:
- Reset (async, any state): state=IDLE, ptr=0, owner=0, operand regs=0, result=0, op_cnt=0.
- Reset outputs: gnt0=gnt1=done0=done1=busy=0. No done pulse is ever emitted for an operation interrupted by reset.
- FSM has three states: IDLE, EXEC, DONE.
- IDLE, no req: stay in IDLE.
- IDLE, one req: grant that client.
- IDLE, both req: grant client ptr.
- IDLE, on grant: latch a/b/c of the granted client, set owner, go to EXEC.
- EXEC: the alu2 instance is fed from the latched operands. At the edge leaving EXEC, result <= ALU output; go to DONE.
- DONE: done[owner]=1 for exactly one cycle. At the edge leaving DONE: ptr <= ~owner, op_cnt += 1 unless saturated, go to IDLE.
- Latency: request sampled at edge E0; done high during the cycle after E1, i.e. 3 cycles req-to-done. Throughput is 1 op per 3 cycles under back-to-back load.
- Client rule: req must be low by the cycle after done. IDLE samples req at the end of that cycle; a req still high there is a new request.
- Round-robin: the owner gets lowest priority next time. Alternation is guaranteed when both clients request continuously. A lone requester is served repeatedly.
- Arithmetic: 4-bit, carries discarded (15+1 -> 0; 15+15+1 -> 15). Op code is passed unchanged to alu2.
- Requests arriving in EXEC or DONE wait. Operand changes after the grant have no effect.
- op_cnt at max value stays there (no wrap).

Decomposition:
- Shared package alu2_pkg: op code constants OP_ADD=2'b00, OP_ADDI=2'b01, OP_AND=2'b10, OP_XOR=2'b11; FSM state encodings ST_IDLE, ST_EXEC, ST_DONE.
- One sub-module: the existing alu2 datapath, instantiated once and unmodified.
- Arbitration, FSM, operand/result registers and counter stay in alu2_rr_sched.

Test Plan:
- Reset, then req0 with a0=3, b0=5, c0=00 -> gnt0 high 2 cycles, done0 pulses 3 cycles after the req edge, result=8, op_cnt=1, done1 never high.
- req1 with a1=15, b1=0, c1=01 -> result=0 (wrap) on done1. Then a1=12, b1=10, c1=10 -> result=8; then c1=11 -> result=6.
- req0 and req1 both high from the same edge after reset, held continuously (new ops each time) -> grant order 0,1,0,1; every completion 3 cycles apart; done0/done1 never together.
- Assert rst during EXEC of a client-0 op -> all outputs 0 immediately; no done0; after release with only req1 high -> client 1 served first, result correct.
- Change a0 from 2 to 9 in EXEC (op 2+4, c0=00) -> result=6.
- 300 back-to-back completions with CNT_W=8 -> op_cnt reaches 255 and holds.
